serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: minuend, captured on the accepted start edge.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend, captured on the accepted start edge.
REQ-007 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 SHALL have port diff, output, WIDTH bits: registered result a-b modulo 2^WIDTH.
REQ-010 SHALL have port borrow, output, 1 bit: registered final borrow, 1 when a<b unsigned.
REQ-011 SHALL have port zero, output, 1 bit: registered flag, 1 when the diff value just produced is 0.

Function
REQ-012 SHALL implement a three-state machine: IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE with start=1 at an edge, do four things: capture a and b into internal shift registers, clear the internal borrow, clear the bit counter, and enter RUN.
REQ-014 SHALL, in IDLE with start=0, stay in IDLE.
REQ-015 SHALL, in RUN, process one bit per edge, LSB first: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 SHALL increment the counter each RUN edge, and enter DONE on the edge that processes bit WIDTH-1.
REQ-017 SHALL, on that same edge, load diff, borrow and zero from the completed computation.
REQ-018 SHALL give latency: start accepted at edge 0; RUN during edges 1..WIDTH; done=1 in the cycle after edge WIDTH.
REQ-019 SHALL hold done=1 for exactly one cycle, then return from DONE to IDLE unconditionally.
REQ-020 SHALL ignore start in RUN and DONE; those requests are dropped and not queued.
REQ-021 SHALL hold diff, borrow and zero stable from completion until the next completion; a new computation does not disturb them before its own done.
REQ-022 SHALL drive busy combinationally from state (busy = state==RUN).
REQ-023 SHALL ignore changes on a and b after capture.
REQ-024 SHALL treat equal operands as valid input: diff=0, borrow=0, zero=1.
REQ-025 SHALL produce only modulo-2^WIDTH results; no saturation and no signed-overflow flag.

Reset
REQ-026 SHALL, when rst_n=0, immediately force the following regardless of clk: state=IDLE, counter=0, internal borrow=0, shift registers=0, busy=0, done=0, diff=0, borrow=0, zero=0.
REQ-027 SHALL abandon a computation when rst_n is asserted mid-RUN; no done pulse is produced for it.
REQ-028 SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-029 SHALL pass this WIDTH=8 case: a=5, b=3, start 1 cycle -> done at edge 9 after acceptance, diff=0x02, borrow=0, zero=0.
REQ-030 SHALL pass this WIDTH=8 case: a=3, b=5 -> diff=0xFE, borrow=1, zero=0.
REQ-031 SHALL pass this WIDTH=8 case: a=0x80, b=0x80 -> diff=0x00, borrow=0, zero=1; also a=0x00, b=0xFF -> diff=0x01, borrow=1.
REQ-032 SHALL pass this WIDTH=8 case: start pulsed again at edges 3 and 9 of a running job (a=0x10, b=0x01), with a and b changed meanwhile -> single done, diff=0x0F, next job only on a later IDLE start.
REQ-033 SHALL pass this WIDTH=8 case: rst_n low at RUN edge 4 of a=0xAA, b=0x55 -> busy=0 and diff=0 at once, no done; after release, start with a=0xAA, b=0x55 -> diff=0x55, borrow=0.
REQ-034 SHALL pass this WIDTH=4 case: a=0x2, b=0x7 -> done at edge 5, diff=0xB, borrow=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor computing diff = a - b (mod 2^WIDTH).
//   A start seen in IDLE captures both operands. RUN then retires one bit
//   per clock, LSB first. The result registers are loaded on the edge that
//   retires the MSB, and done pulses for one cycle (DONE) before the
//   machine returns to IDLE.
//
// Parameters
//   WIDTH  : operand/result width in bits (2..32)
//
// Ports
//   clk    : clock, rising-edge active
//   rst_n  : asynchronous active-low reset
//   start  : subtraction request, only honoured in IDLE
//   a, b   : minuend / subtrahend, captured on the accepted start edge
//   busy   : high while in RUN (decoded from state)
//   done   : one-cycle completion pulse
//   diff   : registered result a - b mod 2^WIDTH
//   borrow : registered final borrow (a < b unsigned)
//   zero   : registered flag, diff just produced is zero
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_zero;

  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSBs of the operand shifters.
  always_comb begin
    w_d        = r_a[0] ^ r_b[0] ^ r_br;
    w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    w_last     = (r_cnt == LAST);
    // Result bits enter at the MSB, so after WIDTH shifts bit 0 sits at [0].
    w_res_next = {w_d, r_res[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_diff   <= w_res_next;
            r_borrow <= w_br_next;
            r_zero   <= (w_res_next == '0);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign zero   = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int unsigned W  = 8;
  localparam int unsigned W4 = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  diff;
  logic          borrow;
  logic          zero;

  logic          start4;
  logic [W4-1:0] a4;
  logic [W4-1:0] b4;
  logic          busy4;
  logic          done4;
  logic [W4-1:0] diff4;
  logic          borrow4;
  logic          zero4;

  int n_pass  = 0;
  int n_total = 0;

  // Last completed result expected on the 8-bit DUT (held between jobs).
  logic [W-1:0] prev_diff;
  logic         prev_borrow;
  logic         prev_zero;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
  );

  serial_subtractor #(.WIDTH(W4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4),
    .zero   (zero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ediff;
    logic         eborrow;
    logic         ezero;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Launches one job on the 8-bit DUT and checks latency, pulse width,
  // result hold during the run, and the final registered result.
  task automatic run_job(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [W-1:0] ed, input logic eb, input logic ez,
                         input string tag);
    int lat;
    int ndone;
    lat   = -1;
    ndone = 0;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check({tag, ".busy_after_accept"}, 32'(busy), 32'd1);
    for (int k = 1; k <= int'(W) + 3; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (k == 3) begin
        check({tag, ".diff_hold"}, 32'(diff), 32'(prev_diff));
        check({tag, ".borrow_hold"}, 32'(borrow), 32'(prev_borrow));
        check({tag, ".zero_hold"}, 32'(zero), 32'(prev_zero));
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'(W));
    check({tag, ".done_count"}, 32'(ndone), 32'd1);
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    check({tag, ".diff"}, 32'(diff), 32'(ed));
    check({tag, ".borrow"}, 32'(borrow), 32'(eb));
    check({tag, ".zero"}, 32'(zero), 32'(ez));
    prev_diff   = ed;
    prev_borrow = eb;
    prev_zero   = ez;
  endtask

  task automatic run_job4(input logic [W4-1:0] ta, input logic [W4-1:0] tb_v,
                          input logic [W4-1:0] ed, input logic eb, input logic ez,
                          input string tag);
    int lat;
    int ndone;
    lat   = -1;
    ndone = 0;
    @(negedge clk);
    a4 = ta; b4 = tb_v; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = W4'($urandom);
    b4 = W4'($urandom);
    for (int k = 1; k <= int'(W4) + 3; k++) begin
      @(posedge clk); #1;
      if (done4) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'(W4));
    check({tag, ".done_count"}, 32'(ndone), 32'd1);
    check({tag, ".diff"}, 32'(diff4), 32'(ed));
    check({tag, ".borrow"}, 32'(borrow4), 32'(eb));
    check({tag, ".zero"}, 32'(zero4), 32'(ez));
  endtask

  initial begin
    vec_t vecs[8];
    logic [W-1:0]  ra, rb, rd;
    logic [W4-1:0] ra4, rb4, rd4;
    int ndone, done_edge;
    logic saw_done;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    prev_diff = '0; prev_borrow = 1'b0; prev_zero = 1'b0;

    // Reset state
    #3;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.diff", 32'(diff), 32'd0);
    check("rst.borrow", 32'(borrow), 32'd0);
    check("rst.zero", 32'(zero), 32'd0);
    check("rst.busy4", 32'(busy4), 32'd0);

    // Release just after an edge; the job below starts on the very next edge.
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i])
      run_job(vecs[i].va, vecs[i].vb, vecs[i].ediff, vecs[i].eborrow,
              vecs[i].ezero, $sformatf("vec%0d", i));

    // Restarts during RUN (edge 3) and DONE (edge 9) are dropped.
    ndone = 0; done_edge = -1;
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      start = (e == 3 || e == 9);
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (done_edge < 0) done_edge = e;
      end
      if (e == 12) check("restart.busy_e12", 32'(busy), 32'd0);
    end
    check("restart.done_count", 32'(ndone), 32'd1);
    check("restart.done_edge", 32'(done_edge), 32'(W));
    check("restart.diff", 32'(diff), 32'h0F);
    check("restart.borrow", 32'(borrow), 32'd0);
    prev_diff = 8'h0F; prev_borrow = 1'b0; prev_zero = 1'b0;

    // Reset in the middle of a run: outputs clear at once, no done follows.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
    end
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.diff", 32'(diff), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    saw_done = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int e = 0; e < int'(W) + 3; e++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst.no_done", 32'(saw_done), 32'd0);
    prev_diff = '0; prev_borrow = 1'b0; prev_zero = 1'b0;
    run_job(8'hAA, 8'h55, 8'h55, 1'b0, 1'b0, "postrst");

    // Randomized jobs against an arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = (i % 7 == 0) ? ra : W'($urandom);
      rd = ra - rb;
      run_job(ra, rb, rd, (ra < rb), (rd == '0), $sformatf("rnd%0d", i));
    end

    // Narrow instance.
    run_job4(4'h2, 4'h7, 4'hB, 1'b1, 1'b0, "w4.case");
    run_job4(4'h7, 4'h7, 4'h0, 1'b0, 1'b1, "w4.equal");
    for (int i = 0; i < 10; i++) begin
      ra4 = W4'($urandom);
      rb4 = W4'($urandom);
      rd4 = ra4 - rb4;
      run_job4(ra4, rb4, rd4, (ra4 < rb4), (rd4 == '0), $sformatf("w4.rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
